aes_round_ctrl: RTL and testbench

Iterative AES encryption controller. Accepts one 128-bit plaintext block, fetches round keys one at a time from the key-schedule block, and drives the shared combinational round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey) once per round. It holds the round state register and returns the ciphertext over a valid/ready handshake. It sits between the host-side block interface and the round datapath/key-schedule pair.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_round_ctrl.sv | 108 ++++++++++
 tb/tb_aes_round_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES controller definitions: block width, round counts and FSM state type.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  localparam int AES128_NR = 10;
  localparam int AES192_NR = 12;
  localparam int AES256_NR = 14;

  typedef enum logic [2:0] {
    IDLE,
    KEY0,
    RKEY,
    ROUND,
    DONE
  } aes_ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption controller: sequences key fetches and datapath rounds.
// Define AES_ABORT_EN to add the abort input, which returns any busy state to IDLE.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef AES_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_block,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_block,
  output logic                   rk_req,
  output logic [3:0]             rk_idx,
  input  logic                   rk_ack,
  input  logic [AES_BLOCK_W-1:0] rk_data,
  output logic [AES_BLOCK_W-1:0] dp_state,
  output logic [AES_BLOCK_W-1:0] dp_key,
  output logic                   dp_final,
  input  logic [AES_BLOCK_W-1:0] dp_result,
  output logic                   busy
);

  if (!(NR == AES128_NR || NR == AES192_NR || NR == AES256_NR)) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  aes_ctrl_state_t       state_q, state_d;
  logic [AES_BLOCK_W-1:0] st_q, st_d;
  logic [AES_BLOCK_W-1:0] key_q, key_d;
  logic [3:0]             rnd_q, rnd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: if (in_valid) begin
        st_d    = in_block;
        rnd_d   = '0;
        state_d = KEY0;
      end
      KEY0: if (rk_ack) begin
        st_d    = st_q ^ rk_data;
        rnd_d   = 4'd1;
        state_d = RKEY;
      end
      RKEY: if (rk_ack) begin
        key_d   = rk_data;
        state_d = ROUND;
      end
      ROUND: begin
        st_d = dp_result;
        if (rnd_q == NR_L) state_d = DONE;
        else begin
          rnd_d   = rnd_q + 4'd1;
          state_d = RKEY;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef AES_ABORT_EN
    // Abort wins over any ack/handshake; wipe the partial block so nothing lingers.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      st_d    = '0;
      key_d   = '0;
      rnd_d   = '0;
    end
`endif
  end

  // in_ready is gated by rst_n so it reads 0 throughout reset, not just after.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_block = st_q;
  assign rk_req    = (state_q == KEY0) || (state_q == RKEY);
  assign rk_idx    = (state_q == RKEY) ? rnd_q : 4'd0;
  assign dp_state  = st_q;
  assign dp_key    = key_q;
  assign dp_final  = (state_q == ROUND) && (rnd_q == NR_L);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES model supplies datapath, round keys and expected ciphertext.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [127:0] in_block = '0;
  logic         out_ready = 1'b0;

  logic         in_valid_a = 1'b0, in_ready_a, out_valid_a, rk_req_a, rk_ack_a = 1'b0, dp_final_a, busy_a;
  logic [3:0]   rk_idx_a;
  logic [127:0] out_block_a, rk_data_a, dp_state_a, dp_key_a, dp_result_a;
  logic         in_valid_b = 1'b0, in_ready_b, out_valid_b, rk_req_b, rk_ack_b = 1'b1, dp_final_b, busy_b;
  logic [3:0]   rk_idx_b;
  logic [127:0] out_block_b, rk_data_b, dp_state_b, dp_key_b, dp_result_b;
`ifdef AES_ABORT_EN
  logic         abort_a = 1'b0, abort_b = 1'b0;
`endif

  logic [14:0][127:0] rks_a, rks_b;

  // ---------------- behavioural AES ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, e;
    r = 8'h01; e = 8'd254;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, a);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte i of the block sits at row i%4, column i/4, MSB first.
  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] v;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (fin) v = b[4*c+r];
        else v = gmul(b[4*c+r], 8'h02) ^ gmul(b[4*c+(r+1)%4], 8'h03) ^ b[4*c+(r+2)%4] ^ b[4*c+(r+3)%4];
        o[127-8*(4*c+r) -: 8] = v ^ k[127-8*(4*c+r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [14:0][127:0] expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [14:0][127:0] rk;
    rk = '0; rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [14:0][127:0] rk, input int nr);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= nr; r++) s = aes_rnd(s, rk[r], r == nr);
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- environment around the DUTs ----------------
  assign dp_result_a = aes_rnd(dp_state_a, dp_key_a, dp_final_a);
  assign dp_result_b = aes_rnd(dp_state_b, dp_key_b, dp_final_b);
  assign rk_data_a   = rks_a[rk_idx_a];
  assign rk_data_b   = rks_b[rk_idx_b];

  aes_round_ctrl #(.NR(10)) u_a (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_ABORT_EN
    .abort(abort_a),
`endif
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_block(in_block),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_block(out_block_a),
    .rk_req(rk_req_a), .rk_idx(rk_idx_a), .rk_ack(rk_ack_a), .rk_data(rk_data_a),
    .dp_state(dp_state_a), .dp_key(dp_key_a), .dp_final(dp_final_a), .dp_result(dp_result_a),
    .busy(busy_a)
  );

  aes_round_ctrl #(.NR(14)) u_b (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_ABORT_EN
    .abort(abort_b),
`endif
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_block(in_block),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_block(out_block_b),
    .rk_req(rk_req_b), .rk_idx(rk_idx_b), .rk_ack(rk_ack_b), .rk_data(rk_data_b),
    .dp_state(dp_state_b), .dp_key(dp_key_b), .dp_final(dp_final_b), .dp_result(dp_result_b),
    .busy(busy_b)
  );

  // Key-source for DUT a: tied-high or random 0..3 wait cycles per request.
  bit         ack_tied = 1'b1;
  int         dly_a = 0, waits_a = 0, viol_a = 0, fin_a = 0, fin_b = 0;
  logic       prev_req = 1'b0, prev_ack = 1'b0;
  logic [3:0] prev_idx = '0;
  logic [3:0] idx_q [$];
  logic [127:0] fin_key_b = '0;

  always @(negedge clk) begin
    if (ack_tied) rk_ack_a = 1'b1;
    else if (rk_req_a) begin
      if (dly_a > 0) begin rk_ack_a = 1'b0; dly_a--; end
      else begin rk_ack_a = 1'b1; dly_a = $urandom_range(0, 3); end
    end else rk_ack_a = 1'($urandom_range(0, 1));
    if (rk_req_a && rk_ack_a) idx_q.push_back(rk_idx_a);
    if (rk_req_a && !rk_ack_a) waits_a++;
    if (prev_req && !prev_ack && rk_req_a && rk_idx_a != prev_idx) viol_a++;
    prev_req = rk_req_a; prev_ack = rk_ack_a; prev_idx = rk_idx_a;
    if (dp_final_a) fin_a++;
    if (dp_final_b) begin fin_b++; fin_key_b = dp_key_b; end
  end

  localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;

  // Drives one block into DUT a (sel=0) or b (sel=1); returns ciphertext and edges from acceptance.
  task automatic send(input bit sel, input logic [127:0] pt, output logic [127:0] ct, output int edges);
    int g;
    @(negedge clk);
    in_block = pt;
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    g = 0;
    while (!(sel ? in_ready_b : in_ready_a) && g < 50) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    edges = 0;
    while (!(sel ? out_valid_b : out_valid_a) && edges < 300) begin @(posedge clk); #1; edges++; end
    ct = sel ? out_block_b : out_block_a;
  endtask

  task automatic release_out();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    checks++;
    if ({in_ready_a, out_valid_a, rk_req_a, rk_idx_a, busy_a, dp_final_a} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0", {in_ready_a, out_valid_a, rk_req_a, rk_idx_a, busy_a, dp_final_a});
    end
    checks++;
    if ({out_block_a, dp_state_a, dp_key_a} !== 384'b0) begin
      errors++; $display("FAIL reset_data got nonzero want 0");
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL reset_idle in_ready=%b busy=%b want 1/0", in_ready_a, busy_a);
    end
  endtask

  task automatic test_fips128();
    logic [127:0] ct; int e;
    ack_tied = 1'b1;
    rks_a = expand({KEY128, 128'h0}, 4, 10);
    fin_a = 0;
    send(1'b0, PT, ct, e);
    checks++;
    if (ct !== CT128) begin errors++; $display("FAIL fips128_ct got %h want %h", ct, CT128); end
    checks++;
    if (e !== 21) begin errors++; $display("FAIL fips128_latency got %0d want 21", e); end
    checks++;
    if (fin_a !== 1) begin errors++; $display("FAIL fips128_final_cnt got %0d want 1", fin_a); end
    release_out();
  endtask

  task automatic test_random_delay();
    logic [127:0] ct, pt, exp; int e; bit seq_ok;
    ack_tied = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (n == 0) begin pt = PT; rks_a = expand({KEY128, 128'h0}, 4, 10); end
      else begin pt = rnd128(); rks_a = expand({rnd128(), 128'h0}, 4, 10); end
      exp = (n == 0) ? CT128 : aes_enc(pt, rks_a, 10);
      idx_q.delete(); waits_a = 0; viol_a = 0; fin_a = 0;
      send(1'b0, pt, ct, e);
      checks++;
      if (ct !== exp) begin errors++; $display("FAIL rand_ct[%0d] got %h want %h", n, ct, exp); end
      checks++;
      if (e !== 21 + waits_a) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", n, e, 21 + waits_a); end
      seq_ok = (idx_q.size() == 11);
      if (seq_ok) for (int i = 0; i < 11; i++) if (idx_q[i] != 4'(i)) seq_ok = 1'b0;
      checks++;
      if (!seq_ok) begin errors++; $display("FAIL rand_idx_seq[%0d] got %p want 0..10", n, idx_q); end
      checks++;
      if (viol_a !== 0) begin errors++; $display("FAIL rand_idx_stable[%0d] got %0d changes want 0", n, viol_a); end
      checks++;
      if (fin_a !== 1) begin errors++; $display("FAIL rand_final_cnt[%0d] got %0d want 1", n, fin_a); end
      release_out();
    end
    ack_tied = 1'b1;
  endtask

  task automatic test_backpressure();
    logic [127:0] ct, pt1, pt2, exp1, exp2; int e;
    rks_a = expand({rnd128(), 128'h0}, 4, 10);
    pt1 = rnd128(); pt2 = rnd128();
    exp1 = aes_enc(pt1, rks_a, 10); exp2 = aes_enc(pt2, rks_a, 10);
    send(1'b0, pt1, ct, e);
    checks++;
    if (ct !== exp1) begin errors++; $display("FAIL bp_ct1 got %h want %h", ct, exp1); end
    @(negedge clk); in_block = pt2; in_valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_a !== 1'b1 || out_block_a !== exp1 || in_ready_a !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] valid=%b ready=%b blk=%h want 1/0/%h", i, out_valid_a, in_ready_a, out_block_a, exp1);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (in_ready_a !== 1'b1 || busy_a !== 1'b0 || out_valid_a !== 1'b0) begin
      errors++; $display("FAIL bp_handshake_idle in_ready=%b busy=%b valid=%b want 1/0/0", in_ready_a, busy_a, out_valid_a);
    end
    @(posedge clk); #1; in_valid_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || in_ready_a !== 1'b0) begin
      errors++; $display("FAIL bp_next_accept busy=%b in_ready=%b want 1/0", busy_a, in_ready_a);
    end
    e = 0;
    while (!out_valid_a && e < 300) begin @(posedge clk); #1; e++; end
    checks++;
    if (out_block_a !== exp2 || e !== 21) begin
      errors++; $display("FAIL bp_ct2 got %h/%0d want %h/21", out_block_a, e, exp2);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    logic [127:0] ct, pt, exp; int e; bit seen;
    rks_a = expand({KEY128, 128'h0}, 4, 10);
    @(negedge clk); in_block = PT; in_valid_a = 1'b1;
    @(posedge clk); #1; in_valid_a = 1'b0;
    repeat (10) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    checks++;
    if ({in_ready_a, out_valid_a, rk_req_a, rk_idx_a, busy_a, dp_final_a} !== 9'b0) begin
      errors++; $display("FAIL midreset_ctrl got %b want 0", {in_ready_a, out_valid_a, rk_req_a, rk_idx_a, busy_a, dp_final_a});
    end
    checks++;
    if ({out_block_a, dp_state_a, dp_key_a} !== 384'b0) begin
      errors++; $display("FAIL midreset_data got nonzero want 0");
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (out_valid_a || busy_a) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_no_output got activity want none"); end
    pt = rnd128(); exp = aes_enc(pt, rks_a, 10);
    send(1'b0, pt, ct, e);
    checks++;
    if (ct !== exp || e !== 21) begin errors++; $display("FAIL midreset_next got %h/%0d want %h/21", ct, e, exp); end
    release_out();
  endtask

  task automatic test_nr14();
    logic [127:0] ct; int e;
    rks_b = expand(KEY256, 8, 14);
    fin_b = 0;
    send(1'b1, PT, ct, e);
    checks++;
    if (ct !== CT256) begin errors++; $display("FAIL nr14_ct got %h want %h", ct, CT256); end
    checks++;
    if (e !== 29) begin errors++; $display("FAIL nr14_latency got %0d want 29", e); end
    checks++;
    if (fin_b !== 1 || fin_key_b !== rks_b[14]) begin
      errors++; $display("FAIL nr14_final got cnt %0d key %h want 1 %h", fin_b, fin_key_b, rks_b[14]);
    end
    release_out();
  endtask

`ifdef AES_ABORT_EN
  task automatic test_abort();
    logic [127:0] pt2, exp; int e; bit seen;
    ack_tied = 1'b1;
    rks_a = expand({rnd128(), 128'h0}, 4, 10);
    @(negedge clk); in_block = rnd128(); in_valid_a = 1'b1;
    @(posedge clk); #1; in_valid_a = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rk_req_a !== 1'b1 || rk_idx_a !== 4'd3) begin
      errors++; $display("FAIL abort_pre req=%b idx=%0d want 1/3", rk_req_a, rk_idx_a);
    end
    abort_a = 1'b1;
    @(posedge clk); #1; abort_a = 1'b0;
    checks++;
    if (rk_req_a !== 1'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b1) begin
      errors++; $display("FAIL abort_idle req=%b busy=%b in_ready=%b want 0/0/1", rk_req_a, busy_a, in_ready_a);
    end
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (out_valid_a) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_no_output got out_valid want none"); end
    pt2 = rnd128(); exp = aes_enc(pt2, rks_a, 10);
    @(negedge clk); abort_a = 1'b1; in_block = pt2; in_valid_a = 1'b1;
    @(posedge clk); #1; abort_a = 1'b0; in_valid_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL abort_idle_ignored busy=%b want 1", busy_a); end
    e = 0;
    while (!out_valid_a && e < 300) begin @(posedge clk); #1; e++; end
    checks++;
    if (out_block_a !== exp || e !== 21) begin
      errors++; $display("FAIL abort_next got %h/%0d want %h/21", out_block_a, e, exp);
    end
    release_out();
  endtask
`endif

  initial begin
    rks_a = expand({KEY128, 128'h0}, 4, 10);
    rks_b = expand(KEY256, 8, 14);
    test_reset();
    test_fips128();
    test_random_delay();
    test_backpressure();
    test_reset_mid();
    test_nr14();
`ifdef AES_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
